// File: rtl/ifu_pkg.sv
// Shared widths, reset PC and fetch-unit state encoding for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned CPU_WIDTH       = 32;
  localparam int unsigned INST_WIDTH      = 32;
  localparam int unsigned IFU_STATE_WIDTH = 2;

  localparam logic [CPU_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [IFU_STATE_WIDTH-1:0] {
    IFU_S_REQ  = 2'd0,
    IFU_S_WAIT = 2'd1,
    IFU_S_HOLD = 2'd2,
    IFU_S_HALT = 2'd3
  } ifu_state_e;

  // A PC is usable only when word aligned.
  function automatic logic pc_misaligned(input logic [CPU_WIDTH-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction per PC from imem
// and holds it for decode until consumed, then loads the externally computed next PC.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CPU_WIDTH-1:0]  next_pc,
  output logic [CPU_WIDTH-1:0]  curr_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [CPU_WIDTH-1:0]  imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  misalign
);

  ifu_state_e           state;
  logic [CPU_WIDTH-1:0] pc;

  // Request is a pure decode of the state register, so it never depends on inputs.
  assign imem_req_valid = (state == IFU_S_REQ);
  assign imem_req_addr  = pc;
  assign curr_pc        = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IFU_S_REQ;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      case (state)
        IFU_S_REQ: begin
          if (imem_req_ready) begin
            state <= IFU_S_WAIT;
          end
        end
        IFU_S_WAIT: begin
          if (imem_rsp_valid) begin
            inst       <= imem_rsp_data;
            inst_valid <= 1'b1;
            state      <= IFU_S_HOLD;
          end
        end
        IFU_S_HOLD: begin
          // Decode handshake: next PC is taken verbatim; a misaligned one stops fetching.
          if (inst_ready) begin
            pc         <= next_pc;
            inst_valid <= 1'b0;
            if (pc_misaligned(next_pc)) begin
              misalign <= 1'b1;
              state    <= IFU_S_HALT;
            end else begin
              state    <= IFU_S_REQ;
            end
          end
        end
        IFU_S_HALT: begin
          state <= IFU_S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed vector table, hand sequences, and a
// randomized run against a transaction-level fetch model.
module tb_ifu;
  import ifu_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [CPU_WIDTH-1:0]  next_pc;
  logic [CPU_WIDTH-1:0]  curr_pc;
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [CPU_WIDTH-1:0]  imem_req_addr;
  logic                  imem_rsp_valid;
  logic [INST_WIDTH-1:0] imem_rsp_data;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [INST_WIDTH-1:0] inst;
  logic                  misalign;

  int total = 0;
  int bad   = 0;

  ifu dut (
    .clk            (clk),
    .rst            (rst),
    .next_pc        (next_pc),
    .curr_pc        (curr_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        irdy;
    logic [31:0] npc;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_iv;
    logic [31:0] e_inst;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic rdy, input logic rspv, input logic [31:0] rspd,
                     input logic irdy, input logic [31:0] npc, input logic e_req,
                     input logic [31:0] e_pc, input logic e_iv, input logic [31:0] e_inst,
                     input logic e_mis);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.irdy = irdy; v.npc = npc;
    v.e_req = e_req; v.e_pc = e_pc; v.e_iv = e_iv; v.e_inst = e_inst; v.e_mis = e_mis;
    vecs.push_back(v);
  endtask

  // Apply one cycle of inputs, let the edge happen, then sample #1 later.
  task automatic drive(input logic r, input logic rdy, input logic rspv, input logic [31:0] rspd,
                       input logic irdy, input logic [31:0] npc);
    rst = r; imem_req_ready = rdy; imem_rsp_valid = rspv; imem_rsp_data = rspd;
    inst_ready = irdy; next_pc = npc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_pc,
                            input logic e_iv, input logic [31:0] e_inst, input logic e_mis);
    check({tag, ".req_valid"}, 32'(imem_req_valid), 32'(e_req));
    check({tag, ".curr_pc"}, curr_pc, e_pc);
    check({tag, ".req_addr"}, imem_req_addr, e_pc);
    check({tag, ".inst_valid"}, 32'(inst_valid), 32'(e_iv));
    if (e_iv) check({tag, ".inst"}, inst, e_inst);
    check({tag, ".misalign"}, 32'(misalign), 32'(e_mis));
  endtask

  // Random-run reference model state (transaction level)
  logic        m_req, m_ival, m_mis, outstanding;
  logic [31:0] m_pc, m_inst;
  int          cnt;

  task automatic model_reset();
    m_req = 1'b1; m_ival = 1'b0; m_mis = 1'b0; outstanding = 1'b0;
    m_pc = RESET_PC_DEFAULT; m_inst = '0; cnt = 0;
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0; next_pc = '0;
    @(posedge clk);
    #1;

    //   rst rdy rspv rspd          irdy npc           req pc            iv inst          mis
    add(1, 0, 0, 32'h0,            0, 32'h0,          1, 32'h0,          0, 32'h0,          0);
    for (int i = 0; i < 4; i++)    // backpressure
      add(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0, 32'h0,          0);
    add(0, 1, 0, 32'h0,            0, 32'h0,          0, 32'h0,          0, 32'h0,          0);
    add(0, 0, 1, 32'h0000_0013,    0, 32'h0,          0, 32'h0,          1, 32'h0000_0013,  0);
    for (int i = 0; i < 5; i++)    // decode stall, with a spurious response mid-stall
      add(0, 1, (i == 2), 32'hDEAD_BEEF, 0, 32'h40,   0, 32'h0,          1, 32'h0000_0013,  0);
    add(0, 0, 0, 32'h0,            1, 32'h40,         1, 32'h40,         0, 32'h0,          0);
    add(0, 1, 0, 32'h0,            0, 32'h0,          0, 32'h40,         0, 32'h0,          0);
    add(0, 0, 1, 32'h0000_0093,    0, 32'h0,          0, 32'h40,         1, 32'h0000_0093,  0);
    add(0, 0, 0, 32'h0,            1, 32'h42,         0, 32'h42,         0, 32'h0,          1);
    for (int i = 0; i < 3; i++)    // halted: everything ignored
      add(0, 1, 1, 32'h1111_1111,  1, 32'h80,         0, 32'h42,         0, 32'h0,          1);
    add(1, 0, 0, 32'h0,            0, 32'h0,          1, 32'h0,          0, 32'h0,          0);
    add(0, 1, 0, 32'h0,            0, 32'h0,          0, 32'h0,          0, 32'h0,          0);
    add(1, 0, 1, 32'h0000_0077,    0, 32'h0,          1, 32'h0,          0, 32'h0,          0);
    add(0, 0, 0, 32'h0,            0, 32'h0,          1, 32'h0,          0, 32'h0,          0);
    add(0, 1, 0, 32'h0,            0, 32'h0,          0, 32'h0,          0, 32'h0,          0);
    add(0, 0, 1, 32'h0000_0013,    0, 32'h0,          0, 32'h0,          1, 32'h0000_0013,  0);
    add(1, 0, 0, 32'h0,            1, 32'h80,         1, 32'h0,          0, 32'h0,          0);
    add(0, 1, 0, 32'h0,            0, 32'h0,          0, 32'h0,          0, 32'h0,          0);
    add(0, 0, 1, 32'h0000_0033,    0, 32'h0,          0, 32'h0,          1, 32'h0000_0033,  0);
    add(0, 0, 0, 32'h0,            1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC,  0, 32'h0,          0);
    add(0, 1, 0, 32'h0,            0, 32'h0,          0, 32'hFFFF_FFFC,  0, 32'h0,          0);
    add(0, 0, 1, 32'h0000_0073,    0, 32'h0,          0, 32'hFFFF_FFFC,  1, 32'h0000_0073,  0);
    add(0, 0, 0, 32'h0,            1, 32'h0,          1, 32'h0,          0, 32'h0,          0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].rspv, vecs[i].rspd, vecs[i].irdy, vecs[i].npc);
      check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_pc, vecs[i].e_iv,
                 vecs[i].e_inst, vecs[i].e_mis);
    end

    // Fetch with always-ready memory, misalign, then long halt under random inputs.
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    check_outs("seq.wait", 0, 32'h0, 0, 0, 0);
    drive(0, 1, 1, 32'hABCD_0001, 0, 0);
    check_outs("seq.hold", 0, 32'h0, 1, 32'hABCD_0001, 0);
    drive(0, 1, 0, 0, 1, 32'h0000_0101);
    check_outs("seq.mis", 0, 32'h0000_0101, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom);
      check_outs("seq.halt", 0, 32'h0000_0101, 0, 0, 1);
    end

    // Randomized run against the transaction model.
    drive(1, 0, 0, 0, 0, 0);
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic        r, rsp_now, req_fire, inst_fire, rdy, irdy, rspv;
      logic [31:0] npc, rspd;
      check_outs("rand", m_req, m_pc, m_ival, m_inst, m_mis);

      r       = ($urandom_range(0, 299) == 0) || (m_mis && $urandom_range(0, 9) == 0);
      rsp_now = outstanding && (cnt == 0);
      rspv    = rsp_now || (!outstanding && $urandom_range(0, 7) == 0);
      rspd    = $urandom;
      rdy     = ($urandom_range(0, 2) != 0);
      irdy    = 1'($urandom_range(0, 1));
      npc     = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 39) == 0) npc = npc | 32'($urandom_range(1, 3));

      req_fire  = m_req && rdy;
      inst_fire = m_ival && irdy;
      if (r) begin
        model_reset();
      end else begin
        if (outstanding && !rsp_now) cnt--;
        if (rsp_now) begin
          m_ival = 1'b1; m_inst = rspd; outstanding = 1'b0;
        end
        if (req_fire) begin
          m_req = 1'b0; outstanding = 1'b1; cnt = $urandom_range(0, 2);
        end
        if (inst_fire) begin
          m_ival = 1'b0;
          m_pc   = npc;
          if (npc[1:0] != 2'b00) m_mis = 1'b1;
          else                   m_req = 1'b1;
        end
      end
      drive(r, rdy, rspv, rspd, irdy, npc);
    end
    check_outs("rand.end", m_req, m_pc, m_ival, m_inst, m_mis);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
